// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, FSM states and alignment check for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Size code 11 has no legal encoding, so it is reported as misaligned.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: lsu_misaligned = 1'b0;
      SZ_HALF: lsu_misaligned = offset[0];
      SZ_WORD: lsu_misaligned = (offset != 2'b00);
      default: lsu_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane merge for sub-word stores and lane extract for loads
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        load_signed,
  output logic [31:0] merged_word,
  output logic [31:0] load_result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    merged_word = mem_word;
    case (size)
      SZ_BYTE: merged_word[{offset, 3'b000} +: 8]     = store_data[7:0];
      SZ_HALF: merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

  always_comb begin
    byte_sel = mem_word[{offset, 3'b000} +: 8];
    half_sel = mem_word[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_result = {{24{load_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_result = {{16{load_signed & half_sel[15]}}, half_sel};
      default: load_result = mem_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word-memory initiator with byte/half access, RMW sub-word stores and
// alignment checking; one response per accepted request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [31:0]       read_data
);

  localparam int             CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_RD_LAT - 1);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        offset_q, offset_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [31:0]       write_data_q, write_data_d;
  logic              mem_write_en_q, mem_write_en_d;
  logic              mem_read_en_q, mem_read_en_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [31:0] merged_word;
  logic [31:0] load_result;

  lsu_lane_align u_lane_align (
    .mem_word    (read_data),
    .store_data  (wdata_q),
    .size        (size_q),
    .offset      (offset_q),
    .load_signed (signed_q),
    .merged_word (merged_word),
    .load_result (load_result)
  );

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    size_d         = size_q;
    signed_d       = signed_q;
    offset_d       = offset_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    address_d      = address_q;
    write_data_d   = write_data_q;
    mem_write_en_d = mem_write_en_q;
    mem_read_en_d  = mem_read_en_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          offset_d = req_addr[1:0];
          wdata_d  = req_wdata;
          if (lsu_misaligned(req_size, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            address_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_write && req_size == SZ_WORD) begin
              state_d        = ST_WRITE;
              mem_write_en_d = 1'b1;
              write_data_d   = req_wdata;
            end else begin
              state_d       = ST_READ;
              mem_read_en_d = 1'b1;
              cnt_d         = CNT_INIT;
            end
          end
        end
      end
      ST_READ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // read_data is valid during the last enabled cycle only.
          mem_read_en_d = 1'b0;
          if (write_q) begin
            state_d        = ST_WRITE;
            mem_write_en_d = 1'b1;
            write_data_d   = merged_word;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = load_result;
          end
        end
      end
      ST_WRITE: begin
        state_d        = ST_RESP;
        mem_write_en_d = 1'b0;
        resp_valid_d   = 1'b1;
        resp_err_d     = 1'b0;
        resp_rdata_d   = 32'd0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      write_q        <= 1'b0;
      size_q         <= SZ_BYTE;
      signed_q       <= 1'b0;
      offset_q       <= 2'b00;
      wdata_q        <= 32'd0;
      cnt_q          <= '0;
      address_q      <= '0;
      write_data_q   <= 32'd0;
      mem_write_en_q <= 1'b0;
      mem_read_en_q  <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'd0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      size_q         <= size_d;
      signed_q       <= signed_d;
      offset_q       <= offset_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      address_q      <= address_d;
      write_data_q   <= write_data_d;
      mem_write_en_q <= mem_write_en_d;
      mem_read_en_q  <= mem_read_en_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign address      = address_q;
  assign write_data   = write_data_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_read_en  = mem_read_en_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and random checks of load_store_unit against a
// word-array reference memory and arithmetic lane model.
module tb_load_store_unit;

  localparam int LAT    = 3;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [31:0]       read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_RD_LAT(LAT), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .address      (address),
    .write_data   (write_data),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .read_data    (read_data)
  );

  // Word memory: data only appears on the LAT-th consecutive read-enable cycle.
  logic [31:0] mem [0:15];
  logic [31:0] ref_mem [0:15];
  int rd_run = 0;

  always @(posedge clk) begin
    if (mem_write_en) mem[address[5:2]] <= write_data;
    rd_run <= mem_read_en ? rd_run + 1 : 0;
  end

  assign read_data = (mem_read_en && rd_run == LAT - 1) ? mem[address[5:2]] : 32'hA5A5_5A5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] off);
    logic [31:0] v;
    v = word >> (8 * off);
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] mask;
    mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    mask = mask << (8 * off);
    return (old & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  // Issues one request from a negedge, follows it to the handshake, returns on a negedge.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd_obs, output logic [31:0] wd_obs);
    logic        err;
    logic [31:0] exp_rd, exp_wd, exp_addr;
    logic [3:0]  idx;
    int          exp_lat, exp_reads, exp_writes;
    int          lat, reads, writes;
    logic        bad_addr, both, unstable;
    logic [31:0] held_rd;
    logic        held_err;

    idx      = a[5:2];
    exp_addr = {a[31:2], 2'b00};
    err      = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    exp_wd   = 32'd0;
    exp_rd   = 32'd0;
    if (err) begin
      exp_lat = 1; exp_reads = 0; exp_writes = 0;
    end else if (!w) begin
      exp_rd  = model_load(ref_mem[idx], sz, sg, a[1:0]);
      exp_lat = LAT + 1; exp_reads = LAT; exp_writes = 0;
    end else begin
      exp_wd       = model_store(ref_mem[idx], wd, sz, a[1:0]);
      ref_mem[idx] = exp_wd;
      exp_writes   = 1;
      exp_reads    = (sz == 2'd2) ? 0 : LAT;
      exp_lat      = (sz == 2'd2) ? 2 : LAT + 2;
    end

    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; reads = 0; writes = 0; bad_addr = 1'b0; both = 1'b0; wd_obs = 32'd0;
    while (1) begin
      if (mem_read_en) begin
        reads++;
        if (address !== exp_addr) bad_addr = 1'b1;
      end
      if (mem_write_en) begin
        writes++;
        wd_obs = write_data;
        if (address !== exp_addr) bad_addr = 1'b1;
      end
      if (mem_read_en && mem_write_en) both = 1'b1;
      if (resp_valid || lat >= 30) break;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("resp_err", {31'd0, resp_err}, {31'd0, err});
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("read_cycles", reads, exp_reads);
    chk("write_cycles", writes, exp_writes);
    if (exp_writes == 1) chk("write_data", wd_obs, exp_wd);
    chk("mem_address", {31'd0, bad_addr}, 32'd0);
    chk("enables_exclusive", {31'd0, both}, 32'd0);
    rd_obs = resp_rdata;

    held_rd = resp_rdata; held_err = resp_err; unstable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== held_rd || resp_err !== held_err ||
          req_ready !== 1'b0 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0)
        unstable = 1'b1;
    end
    chk("resp_hold_stable", {31'd0, unstable}, 32'd0);

    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_handshake", {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd, wdo;
    logic        flag;

    #2 rst = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {29'd0, resp_valid, resp_err, mem_write_en | mem_read_en}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, rd, wdo);
    end

    do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEAD_BEEF, 0, rd, wdo);
    chk("dir_word_store_wdata", wdo, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 0, rd, wdo);
    chk("dir_word_load", rd, 32'hDEAD_BEEF);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 0, rd, wdo);
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AA, 0, rd, wdo);
    chk("dir_byte_rmw_wdata", wdo, 32'h11AA_3344);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, rd, wdo);
    chk("dir_rmw_readback", rd, 32'h11AA_3344);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'd0, 0, rd, wdo);
    chk("dir_lb_signed", rd, 32'hFFFF_FFAA);
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'd0, 0, rd, wdo);
    chk("dir_lb_unsigned", rd, 32'h0000_00AA);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 0, rd, wdo);
    chk("dir_lh_signed", rd, 32'h0000_11AA);

    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, 0, rd, wdo);
    do_req(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234_5678, 0, rd, wdo);
    do_req(1'b0, 2'd3, 1'b0, 32'h04, 32'd0, 1, rd, wdo);

    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 5, rd, wdo);
    chk("dir_backpressure_load", rd, 32'hDEAD_BEEF);

    // Abort a sub-word RMW partway through its read count.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_read_active", {31'd0, mem_read_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_enables", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("rst_mid_ready", {30'd0, req_ready, resp_valid}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || mem_read_en || mem_write_en) flag = 1'b1;
    end
    chk("rst_mid_quiet", {31'd0, flag}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, 0, rd, wdo);

    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2), rd, wdo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-wide data_memory interface; accepts load/store requests from the pipeline MEM stage and drives data_memory's address, write_data, mem_write_en and mem_read_en.
- Adds byte/halfword access: loads are extracted and sign/zero-extended; sub-word stores use a read-modify-write sequence.
- Checks alignment and returns one response per request through a valid/ready handshake.

Parameters:
- MEM_RD_LAT, 1, cycles from mem_read_en assertion to valid mem_read_data (1..4).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- req_signed  in  1  sign-extend loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low byte/half is used for sub-word stores.
- resp_valid  out  1  response pending.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result; 0 for stores.
- resp_err  out  1  misaligned/illegal request.
- address  out  ADDR_W  to data_memory; bits [1:0] always 0.
- write_data  out  32  to data_memory.
- mem_write_en  out  1  to data_memory.
- mem_read_en  out  1  to data_memory.
- read_data  in  32  from data_memory.

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=1; resp_valid, resp_err, mem_write_en and mem_read_en = 0; resp_rdata, address and write_data = 0.
- All outputs are registered, except req_ready, which is decoded from state.
- States: IDLE, READ, WRITE, RESP.
- IDLE, on req_valid && req_ready: latch the request.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 11) -> RESP with resp_err=1; no memory access.
  - Word store -> WRITE.
  - Any load or sub-word store -> READ.
- READ:
  - address={addr[ADDR_W-1:2],2'b00}; mem_read_en=1 for exactly MEM_RD_LAT cycles (down-counter).
  - read_data is sampled on the edge ending the last READ cycle.
  - Next state: load -> RESP; sub-word store -> WRITE with merged data.
- WRITE:
  - mem_write_en=1 for exactly one cycle; address unchanged from READ.
  - write_data = req_wdata (word) or merged word (sub-word).
  - Next state: RESP.
- RESP: resp_valid=1, held with resp_rdata/resp_err stable until resp_ready; returns to IDLE on the resp_ready cycle.
- Lanes (little-endian):
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
  - Sub-word merge replaces only the addressed lane; other lanes keep the read value.
- Load extension: req_signed=1 replicates the lane MSB; otherwise zero-fill. Word loads ignore req_signed.
- Latency (MEM_RD_LAT=1, resp_ready=1), counted from the accept edge:
  - Load: response visible after 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- mem_read_en and mem_write_en are never asserted in the same cycle.
- Enables are 0 in IDLE and RESP.
- Back-to-back: a new request is accepted only in IDLE, i.e. one cycle after the response handshake.
- Reset mid-operation: FSM aborts and no response is issued. If reset hits during WRITE, the target word's content is undefined; every other memory word is untouched.

Decomposition:
- Package lsu_pkg: size codes (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), state encoding, alignment-check function.
- Sub-module lsu_lane_align (combinational): store-merge (old word, data, size, offset -> new word) and load-extract (word, size, offset, signed -> result).

Test Plan:
- Word store then load: store 0xDEADBEEF @0x08, load word @0x08 -> address=0x08, mem_write_en one cycle, resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store RMW: word @0x10 = 0x11223344; store byte 0xAA @0x12 -> one read cycle then one write cycle with write_data=0x11AA3344; word load reads 0x11AA3344.
- Sign extension: word @0x10 = 0x11AA3344; load byte @0x12 signed -> 0xFFFFFFAA; unsigned -> 0x000000AA; load half @0x12 signed -> 0x000011AA.
- Misalignment: load word @0x06, store half @0x03 -> resp_err=1, resp_rdata=0, no mem_read_en/mem_write_en pulse.
- Backpressure: load with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, no memory enables; completes on resp_ready=1.
- Reset mid-RMW with MEM_RD_LAT=3: assert rst during the READ count -> enables drop immediately, req_ready=1, no resp_valid; next load still returns correct data.
